// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
package demux_pkg;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
  typedef enum logic {LK_IDLE, LK_LOCKED} lock_state_e;

  function automatic logic sel_legal(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/demux_1_to_n_stream_if.sv
// Stream bundle for demux_1_to_n_stream: one tagged input stream, N output channels.
interface demux_1_to_n_stream_if #(
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned SEL_W = $clog2(N_OUT);

  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;

  // Environment side: producer plus the N consumers.
  modport master (
    output in_data, in_sel, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Demux side.
  modport slave (
    input  in_data, in_sel, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready register slice with full throughput and synchronous reset.
module stream_reg_slice
  import demux_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  slot_state_e      state_q, state_d;
  logic [Width-1:0] data_q, data_d;

  // Ready only depends on the consumer, never on in_valid_i.
  assign in_ready_o  = (state_q == SLOT_EMPTY) || out_ready_i;
  assign out_valid_o = (state_q == SLOT_FULL);
  assign out_data_o  = data_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (in_valid_i) begin
          state_d = SLOT_FULL;
          data_d  = in_data_i;
        end
      end
      SLOT_FULL: begin
        if (out_ready_i) begin
          if (in_valid_i) begin
            data_d = in_data_i;
          end else begin
            state_d = SLOT_EMPTY;
          end
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/demux_1_to_n_stream.sv
// Registered 1-to-N stream demultiplexer with illegal-select drop.
// Optional packet locking (route whole packets by first-beat select) via DEMUX_PKT_LOCK_EN.
module demux_1_to_n_stream
  import demux_pkg::*;
#(
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  demux_1_to_n_stream_if.slave bus,
  output logic                 sel_err_o
);

  localparam int unsigned SEL_W = $clog2(N_OUT);
  localparam int unsigned PAY_W = DATA_W + SEL_W;

  logic [SEL_W-1:0]        route_sel, held_sel;
  logic [DATA_W-1:0]       held_data;
  logic                    legal, first_beat, in_acc;
  logic                    slot_in_valid, slot_in_ready, slot_out_valid, slot_out_ready;
  logic                    sel_err_q, sel_err_d;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT*DATA_W-1:0] out_data;

`ifdef DEMUX_PKT_LOCK_EN
  lock_state_e      lock_q, lock_d;
  logic [SEL_W-1:0] locked_sel_q, locked_sel_d;

  // An illegal first-beat select stays locked, so the rest of the packet drops silently.
  always_comb begin
    lock_d       = lock_q;
    locked_sel_d = locked_sel_q;
    route_sel    = (lock_q == LK_LOCKED) ? locked_sel_q : bus.in_sel;
    first_beat   = (lock_q == LK_IDLE);
    if (in_acc) begin
      unique case (lock_q)
        LK_IDLE: begin
          if (!bus.in_last) begin
            lock_d       = LK_LOCKED;
            locked_sel_d = bus.in_sel;
          end
        end
        LK_LOCKED: begin
          if (bus.in_last) lock_d = LK_IDLE;
        end
        default: lock_d = LK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q       <= LK_IDLE;
      locked_sel_q <= '0;
    end else begin
      lock_q       <= lock_d;
      locked_sel_q <= locked_sel_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = bus.in_last;
  assign route_sel   = bus.in_sel;
  assign first_beat  = 1'b1;
`endif

  assign legal         = sel_legal(32'(route_sel), N_OUT);
  assign in_acc        = bus.in_valid && slot_in_ready;
  assign slot_in_valid = bus.in_valid && legal;
  assign sel_err_d     = in_acc && !legal && first_beat;
  assign bus.in_ready  = slot_in_ready;

  stream_reg_slice #(
    .Width (PAY_W)
  ) u_slot (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   ({route_sel, bus.in_data}),
    .in_valid_i  (slot_in_valid),
    .in_ready_o  (slot_in_ready),
    .out_data_o  ({held_sel, held_data}),
    .out_valid_o (slot_out_valid),
    .out_ready_i (slot_out_ready)
  );

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      out_valid[k] = slot_out_valid && (held_sel == SEL_W'(k));
      if (out_valid[k]) out_data[k*DATA_W +: DATA_W] = held_data;
    end
  end

  // Only the channel holding the beat can drain the slot.
  assign slot_out_ready = |(out_valid & bus.out_ready);
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  assign sel_err_o = sel_err_q;

endmodule

// File: tb/tb_demux_1_to_n_stream.sv
// Directed bench for demux_1_to_n_stream: a 4-channel and a 3-channel instance.
module tb_demux_1_to_n_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err4, err3;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  demux_1_to_n_stream_if #(.N_OUT(4), .DATA_W(8)) bus4 ();
  demux_1_to_n_stream_if #(.N_OUT(3), .DATA_W(8)) bus3 ();

  demux_1_to_n_stream #(.N_OUT(4), .DATA_W(8)) u_dut4 (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus4),
    .sel_err_o (err4)
  );

  demux_1_to_n_stream #(.N_OUT(3), .DATA_W(8)) u_dut3 (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus3),
    .sel_err_o (err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive4(input logic v, input logic [7:0] d, input logic [1:0] s, input logic l);
    bus4.in_valid = v;
    bus4.in_data  = d;
    bus4.in_sel   = s;
    bus4.in_last  = l;
  endtask

  task automatic drive3(input logic v, input logic [7:0] d, input logic [1:0] s);
    bus3.in_valid = v;
    bus3.in_data  = d;
    bus3.in_sel   = s;
    bus3.in_last  = 1'b0;
  endtask

  initial begin
    drive4(1'b1, 8'h33, 2'd0, 1'b0);
    drive3(1'b0, 8'h00, 2'd0);
    bus4.out_ready = 4'b1111;
    bus3.out_ready = 3'b000;

    // Reset held for two edges while a beat is offered.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_out_valid", 32'(bus4.out_valid), 32'h0);
      chk("rst_out_data", bus4.out_data, 32'h0);
      chk("rst_sel_err", 32'(err4), 32'h0);
    end
    rst = 1'b0;
    drive4(1'b0, 8'h00, 2'd0, 1'b0);
    chk("rst_in_ready", 32'(bus4.in_ready), 32'h1);

    // Single route to channel 2.
    drive4(1'b1, 8'hA5, 2'd2, 1'b0);
    tick();
    drive4(1'b0, 8'h00, 2'd0, 1'b0);
    chk("route_valid", 32'(bus4.out_valid), 32'h4);
    chk("route_data", bus4.out_data, 32'h00A5_0000);
    tick();
    chk("route_drain", 32'(bus4.out_valid), 32'h0);

    // Backpressure on channel 1.
    bus4.out_ready = 4'b1101;
    drive4(1'b1, 8'h11, 2'd1, 1'b0);
    tick();
    drive4(1'b1, 8'h22, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(bus4.in_ready), 32'h0);
      chk("bp_hold_valid", 32'(bus4.out_valid), 32'h2);
      chk("bp_hold_data", bus4.out_data, 32'h0000_1100);
      tick();
    end
    bus4.out_ready = 4'b1111;
    #1;
    chk("bp_release_ready", 32'(bus4.in_ready), 32'h1);
    tick();
    drive4(1'b0, 8'h00, 2'd0, 1'b0);
    chk("bp_second_valid", 32'(bus4.out_valid), 32'h2);
    chk("bp_second_data", bus4.out_data, 32'h0000_2200);
    tick();
    chk("bp_empty", 32'(bus4.out_valid), 32'h0);

    // Back-to-back across all channels.
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 8'(8'h40 + i), 2'(i), 1'b0);
      chk("b2b_in_ready", 32'(bus4.in_ready), 32'h1);
      tick();
      chk("b2b_valid", 32'(bus4.out_valid), 32'(1) << i);
      chk("b2b_data", bus4.out_data, 32'(8'h40 + i) << (8 * i));
    end
    drive4(1'b0, 8'h00, 2'd0, 1'b0);
    tick();
    chk("b2b_empty", 32'(bus4.out_valid), 32'h0);
    chk("b2b_no_err", 32'(err4), 32'h0);

    // Illegal select on the 3-channel build, empty slot.
    drive3(1'b1, 8'h77, 2'd3);
    chk("ill_in_ready", 32'(bus3.in_ready), 32'h1);
    tick();
    drive3(1'b0, 8'h00, 2'd0);
    chk("ill_err", 32'(err3), 32'h1);
    chk("ill_valid", 32'(bus3.out_valid), 32'h0);
    tick();
    chk("ill_err_pulse", 32'(err3), 32'h0);

    // Illegal select while a beat is held on channel 0.
    drive3(1'b1, 8'h5A, 2'd0);
    tick();
    drive3(1'b1, 8'h77, 2'd3);
    chk("ill_held_ready", 32'(bus3.in_ready), 32'h0);
    tick();
    chk("ill_held_valid", 32'(bus3.out_valid), 32'h1);
    chk("ill_held_data", 32'(bus3.out_data), 32'h0000_005A);
    chk("ill_held_no_err", 32'(err3), 32'h0);
    bus3.out_ready = 3'b001;
    tick();
    drive3(1'b0, 8'h00, 2'd0);
    chk("ill_drain_err", 32'(err3), 32'h1);
    chk("ill_drain_valid", 32'(bus3.out_valid), 32'h0);
    tick();
    chk("ill_drain_pulse", 32'(err3), 32'h0);

`ifdef DEMUX_PKT_LOCK_EN
    // Three-beat packet locked to channel 1 despite changing select.
    drive4(1'b1, 8'h01, 2'd1, 1'b0);
    tick();
    chk("lk_b1_valid", 32'(bus4.out_valid), 32'h2);
    drive4(1'b1, 8'h02, 2'd3, 1'b0);
    tick();
    chk("lk_b2_valid", 32'(bus4.out_valid), 32'h2);
    chk("lk_b2_data", bus4.out_data, 32'h0000_0200);
    drive4(1'b1, 8'h03, 2'd0, 1'b1);
    tick();
    chk("lk_b3_valid", 32'(bus4.out_valid), 32'h2);
    chk("lk_b3_data", bus4.out_data, 32'h0000_0300);
    drive4(1'b1, 8'h04, 2'd2, 1'b1);
    tick();
    chk("lk_next_valid", 32'(bus4.out_valid), 32'h4);
    // Reset in the middle of a packet re-samples the select.
    drive4(1'b1, 8'h05, 2'd3, 1'b0);
    tick();
    chk("lk_pre_rst_valid", 32'(bus4.out_valid), 32'h8);
    rst = 1'b1;
    drive4(1'b0, 8'h00, 2'd0, 1'b0);
    tick();
    rst = 1'b0;
    drive4(1'b1, 8'h06, 2'd0, 1'b1);
    tick();
    drive4(1'b0, 8'h00, 2'd0, 1'b0);
    chk("lk_post_rst_valid", 32'(bus4.out_valid), 32'h1);
    chk("lk_post_rst_data", bus4.out_data, 32'h0000_0006);
    tick();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
